// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default constants for the next-PC generator
// Purpose: state encoding for the next-PC FSM and default address/increment values.
// Contents: pc_state_e (ST_BOOT, ST_RUN, ST_PEND), DEF_RESET_PC, DEF_EXC_PC, DEF_INC.
package pc_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } pc_state_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_PC   = 32'h0000_0080;
   localparam logic [31:0] DEF_INC      = 32'd4;

endpackage

// File: rtl/pc_target_sel.sv
// rtl/pc_target_sel.sv - redirect target priority select and alignment check
// Purpose: combinational choice of the redirect target (jump over branch) and of the
//   target actually applied to the PC (new request, else the held pending target).
// Config macro: PC_ALIGN_CHECK_EN - misaligned applied targets are replaced by EXC_PC.
// Ports:
//   jump, jump_target        - unconditional redirect request and destination
//   branch_taken, branch_target - taken branch and destination
//   pend_target              - target held from an earlier stalled redirect
//   redirect                 - any redirect requested this cycle
//   new_target               - priority-selected target of this cycle's request
//   apply_target             - target to drive onto PCNext when a redirect is applied
//   misaligned               - apply_target was substituted by EXC_PC (0 when check is off)
module pc_target_sel
   import pc_pkg::*;
#(
   parameter logic [31:0] EXC_PC = DEF_EXC_PC
) (
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] pend_target,
   output logic        redirect,
   output logic [31:0] new_target,
   output logic [31:0] apply_target,
   output logic        misaligned
);

   logic [31:0] raw_target;

   assign redirect   = jump | branch_taken;
   assign new_target = jump ? jump_target : branch_target;
   // A fresh request in the release cycle beats the held target.
   assign raw_target = redirect ? new_target : pend_target;

`ifdef PC_ALIGN_CHECK_EN
   // Checked at application time so a misaligned target may sit in pend_target harmlessly.
   assign misaligned   = (raw_target[1:0] != 2'b00);
   assign apply_target = misaligned ? EXC_PC : raw_target;
`else
   logic unused_exc_pc;
   assign unused_exc_pc = ^EXC_PC;
   assign misaligned    = 1'b0;
   assign apply_target  = raw_target;
`endif

endmodule

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - next-PC generator with boot, redirect, stall and pending redirect
// Purpose: drives PCNext for the program counter register, holding a redirect that arrives
//   during a stall until the stall releases, and flags wrong-path fetches via Squash.
// Config macro: PC_ALIGN_CHECK_EN - misaligned targets vector to EXC_PC and pulse AlignErr.
// Ports:
//   Clk, Rst_n           - clock (rising edge), asynchronous active-low reset
//   PCResult             - current PC from the program counter register
//   Stall                - hold the PC
//   Jump, JumpTarget     - unconditional redirect (higher priority)
//   BranchTaken, BranchTarget - taken branch redirect
//   PCNext               - next PC (combinational)
//   Squash               - discard the instruction currently in IF
//   RedirectPending      - a stalled redirect is being held
//   AlignErr             - registered one-cycle pulse after a misaligned redirect is applied
module pc_next_logic
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
   parameter logic [31:0] INC      = DEF_INC
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [31:0] PCResult,
   input  logic        Stall,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   output logic [31:0] PCNext,
   output logic        Squash,
   output logic        RedirectPending,
   output logic        AlignErr
);

   pc_state_e   state, state_nxt;
   logic [31:0] pend_target, pend_target_nxt;
   logic        redirect;
   logic [31:0] new_target;
   logic [31:0] apply_target;
   logic        misaligned;
   logic        apply;

   pc_target_sel #(
      .EXC_PC (EXC_PC)
   ) u_target_sel (
      .jump          (Jump),
      .jump_target   (JumpTarget),
      .branch_taken  (BranchTaken),
      .branch_target (BranchTarget),
      .pend_target   (pend_target),
      .redirect      (redirect),
      .new_target    (new_target),
      .apply_target  (apply_target),
      .misaligned    (misaligned)
   );

   always_comb begin
      state_nxt       = state;
      pend_target_nxt = pend_target;
      PCNext          = PCResult + INC;
      Squash          = 1'b0;
      apply           = 1'b0;
      case (state)
         ST_BOOT: begin
            PCNext    = RESET_PC;
            Squash    = 1'b1;
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (redirect && !Stall) begin
               PCNext = apply_target;
               Squash = 1'b1;
               apply  = 1'b1;
            end else if (redirect) begin
               // Hold the PC and remember where to go once the stall clears.
               PCNext          = PCResult;
               pend_target_nxt = new_target;
               state_nxt       = ST_PEND;
            end else if (Stall) begin
               PCNext = PCResult;
            end
         end
         ST_PEND: begin
            if (Stall) begin
               PCNext = PCResult;
               if (redirect) begin
                  pend_target_nxt = new_target;
               end
            end else begin
               PCNext    = apply_target;
               Squash    = 1'b1;
               apply     = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         default: begin
            PCNext    = RESET_PC;
            Squash    = 1'b1;
            state_nxt = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state       <= ST_BOOT;
         pend_target <= 32'h0;
      end else begin
         state       <= state_nxt;
         pend_target <= pend_target_nxt;
      end
   end

   assign RedirectPending = (state == ST_PEND);

`ifdef PC_ALIGN_CHECK_EN
   logic align_err;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         align_err <= 1'b0;
      end else begin
         align_err <= apply & misaligned;
      end
   end

   assign AlignErr = align_err;
`else
   logic unused_align;
   assign unused_align = apply ^ misaligned;
   assign AlignErr     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_logic.sv
// tb/tb_pc_next_logic.sv - scoreboard bench for pc_next_logic with directed vectors
module tb_pc_next_logic;

   typedef struct {
      string       name;
      logic [31:0] pcr;
      logic [31:0] pcn;
      logic        sq;
      logic        rp;
      logic        ae;
   } exp_t;

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [31:0] A_PCN = 32'h0000_0080;
   localparam logic        A_AE  = 1'b1;
`else
   localparam logic [31:0] A_PCN = 32'h0000_0202;
   localparam logic        A_AE  = 1'b0;
`endif
   localparam logic [31:0] A_P1 = A_PCN + 32'd4;
   localparam logic [31:0] A_P2 = A_PCN + 32'd8;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic [31:0] PCResult = 32'h0;
   logic        Stall = 1'b0;
   logic        Jump = 1'b0;
   logic [31:0] JumpTarget = 32'h0;
   logic        BranchTaken = 1'b0;
   logic [31:0] BranchTarget = 32'h0;
   logic [31:0] PCNext;
   logic        Squash;
   logic        RedirectPending;
   logic        AlignErr;

   logic        load_en = 1'b0;
   logic [31:0] load_val = 32'h0;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   pc_next_logic dut (
      .Clk             (Clk),
      .Rst_n           (Rst_n),
      .PCResult        (PCResult),
      .Stall           (Stall),
      .Jump            (Jump),
      .JumpTarget      (JumpTarget),
      .BranchTaken     (BranchTaken),
      .BranchTarget    (BranchTarget),
      .PCNext          (PCNext),
      .Squash          (Squash),
      .RedirectPending (RedirectPending),
      .AlignErr        (AlignErr)
   );

   always #5 Clk = ~Clk;

   // Program counter register model; load_en lets the bench plant a PC value.
   always @(posedge Clk) begin
      PCResult <= load_en ? load_val : PCNext;
   end

   task automatic step(input string name, input logic rst, input logic st,
                       input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt,
                       input logic ld, input logic [31:0] lv,
                       input logic [31:0] e_pcr, input logic [31:0] e_pcn,
                       input logic e_sq, input logic e_rp, input logic e_ae);
      exp_t e;
      @(posedge Clk);
      #1;
      Rst_n        = rst;
      Stall        = st;
      Jump         = j;
      JumpTarget   = jt;
      BranchTaken  = b;
      BranchTarget = bt;
      load_en      = ld;
      load_val     = lv;
      e.name = name;
      e.pcr  = e_pcr;
      e.pcn  = e_pcn;
      e.sq   = e_sq;
      e.rp   = e_rp;
      e.ae   = e_ae;
      exp_q.push_back(e);
   endtask

   // Monitor: every cycle with a queued expectation is compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (PCResult !== e.pcr || PCNext !== e.pcn || Squash !== e.sq ||
                RedirectPending !== e.rp || AlignErr !== e.ae) begin
               n_bad++;
               $display("FAIL %s: got pcr=%h pcn=%h sq=%b rp=%b ae=%b, need pcr=%h pcn=%h sq=%b rp=%b ae=%b",
                        e.name, PCResult, PCNext, Squash, RedirectPending, AlignErr,
                        e.pcr, e.pcn, e.sq, e.rp, e.ae);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //    name          rst st j jt            b bt            ld lv            pcr           pcn           sq rp ae
      step("reset0",      0, 0, 1, 32'h0000_0200, 1, 32'h40, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
      step("reset1",      0, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
      step("reset2",      0, 1, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
      step("release",     1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
      step("seq0",        1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h0, 32'h4, 0, 0, 0);
      step("seq4",        1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h4, 32'h8, 0, 0, 0);
      step("seq8",        1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h8, 32'hC, 0, 0, 0);
      step("seq12",       1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'hC, 32'h10, 0, 0, 0);
      step("jump",        1, 0, 1, 32'h200,       0, 32'h0,  0, 32'h0, 32'h10, 32'h200, 1, 0, 0);
      step("jump_land",   1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h200, 32'h204, 0, 0, 0);
      step("br_stall",    1, 1, 0, 32'h0,         1, 32'h40, 0, 32'h0, 32'h204, 32'h204, 0, 0, 0);
      step("pend_hold1",  1, 1, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h204, 32'h204, 0, 1, 0);
      step("pend_hold2",  1, 1, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h204, 32'h204, 0, 1, 0);
      step("pend_rel",    1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h204, 32'h40, 1, 1, 0);
      step("br_land",     1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h40, 32'h44, 0, 0, 0);
      step("jb_stall",    1, 1, 1, 32'h300,       1, 32'h80, 0, 32'h0, 32'h44, 32'h44, 0, 0, 0);
      step("pend_over",   1, 1, 0, 32'h0,         1, 32'h90, 0, 32'h0, 32'h44, 32'h44, 0, 1, 0);
      step("over_rel",    1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h44, 32'h90, 1, 1, 0);
      step("jb_prio",     1, 0, 1, 32'h300,       1, 32'h80, 0, 32'h0, 32'h90, 32'h300, 1, 0, 0);
      step("prio_land",   1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h300, 32'h304, 0, 0, 0);
      step("br_stall2",   1, 1, 0, 32'h0,         1, 32'h500, 0, 32'h0, 32'h304, 32'h304, 0, 0, 0);
      step("rel_newjmp",  1, 0, 1, 32'h600,       0, 32'h0,  0, 32'h0, 32'h304, 32'h600, 1, 1, 0);
      step("newjmp_land", 1, 0, 0, 32'h0,         0, 32'h0,  1, 32'hFFFF_FFFC, 32'h600, 32'h604, 0, 0, 0);
      step("wrap",        1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'hFFFF_FFFC, 32'h0, 0, 0, 0);
      step("wrap_land",   1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h0, 32'h4, 0, 0, 0);
      step("mis_jump",    1, 0, 1, 32'h202,       0, 32'h0,  0, 32'h0, 32'h4, A_PCN, 1, 0, 0);
      step("mis_pulse",   1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, A_PCN, A_P1, 0, 0, A_AE);
      step("mis_after",   1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, A_P1, A_P2, 0, 0, 0);
      step("rst_stall",   1, 1, 0, 32'h0,         1, 32'h700, 0, 32'h0, A_P2, A_P2, 0, 0, 0);
      step("rst_pend",    1, 1, 0, 32'h0,         0, 32'h0,  0, 32'h0, A_P2, A_P2, 0, 1, 0);
      step("rst_async",   0, 1, 0, 32'h0,         0, 32'h0,  0, 32'h0, A_P2, 32'h0, 1, 0, 0);
      step("rst_boot",    1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
      step("rst_run",     1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h0, 32'h4, 0, 0, 0);

      repeat (3) @(negedge Clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
